// File: rtl/data_ram.sv
// data_ram -- parametrised synchronous data memory for the MIPS datapath.
//
// Word-addressed RAM with byte-lane writes, a registered read pipeline of
// READ_LAT stages with a valid strobe, sticky out-of-range detection and an
// optional post-reset clearing sweep.
//
// Optional feature macro: DATA_RAM_INIT_CLEAR_EN
//   defined   : after reset an INIT sweep writes zero to every word, one per
//               cycle, with ready=0; ready rises DEPTH edges after reset.
//   undefined : no sweep, ready is tied high, contents undefined until written.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   memRead    : read request (sampled when ready=1)
//   memWrite   : write request (sampled when ready=1)
//   addr       : word address
//   byteEn     : per-byte write enable, bit i covers bits [8i+7:8i]
//   writeData  : write data
//   readData   : read data, zero unless readValid=1
//   readValid  : one-cycle strobe per accepted read
//   ready      : block accepts requests
//   addrErr    : sticky flag, set by any accepted access with addr >= DEPTH
module data_ram #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   byteEn,
  input  logic [DATA_W-1:0]     writeData,
  output logic [DATA_W-1:0]     readData,
  output logic                  readValid,
  output logic                  ready,
  output logic                  addrErr
);

  localparam int NB   = DATA_W / 8;
  localparam int LAST = READ_LAT - 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic in_range;
  logic rd_acc;
  logic wr_acc;

  // One extra bit so DEPTH == 2**ADDR_W compares correctly.
  assign in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
  assign rd_acc   = ready & memRead;
  assign wr_acc   = ready & memWrite;

`ifdef DATA_RAM_INIT_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN:     ;
        default: state <= INIT;
      endcase
    end
  end

  assign ready = ready_q;
`else
  assign ready = 1'b1;
`endif

  // Array write port: no reset, contents survive rst_n.
  always_ff @(posedge clk) begin
`ifdef DATA_RAM_INIT_CLEAR_EN
    if (state == INIT) begin
      mem[clr_cnt] <= '0;
    end else
`endif
    if (wr_acc && in_range) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (byteEn[i]) begin
          mem[addr][8*i +: 8] <= writeData[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline. Stage 0 samples the array at the accept edge with
  // non-blocking semantics, so a same-edge write is not seen (read-first).
  logic              pv [READ_LAT];
  logic [DATA_W-1:0] pd [READ_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= rd_acc;
      pd[0] <= (rd_acc && in_range) ? mem[addr] : '0;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrErr <= 1'b0;
    end else if ((rd_acc || wr_acc) && !in_range) begin
      addrErr <= 1'b1;
    end
  end

  assign readValid = pv[LAST];
  assign readData  = pv[LAST] ? pd[LAST] : '0;

endmodule

// File: tb/tb_data_ram.sv
module tb_data_ram;

  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int DEP = 200;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          memRead;
  logic          memWrite;
  logic [AW-1:0] addr;
  logic [1:0]    byteEn;
  logic [DW-1:0] writeData;
  logic [DW-1:0] readData;
  logic          readValid;
  logic          ready;
  logic          addrErr;

  data_ram #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .DEPTH   (DEP),
    .READ_LAT(LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .memRead  (memRead),
    .memWrite (memWrite),
    .addr     (addr),
    .byteEn   (byteEn),
    .writeData(writeData),
    .readData (readData),
    .readValid(readValid),
    .ready    (ready),
    .addrErr  (addrErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t sb [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: compares every presented read against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && readValid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(readValid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("read_data", 32'(readData), 32'(e.d));
        chk("read_latency", 32'(cyc), 32'(e.due));
      end
    end else if (readValid !== 1'b1) begin
      chk("data_zero_when_idle", 32'(readData), 32'd0);
    end
  end

  // Drive one request, accepted at the next rising edge.
  task automatic op(input logic rd, input logic wr, input logic [AW-1:0] a,
                    input logic [1:0] be, input logic [DW-1:0] wd,
                    input logic [DW-1:0] exp, input logic push);
    @(posedge clk); #1;
    memRead   = rd;
    memWrite  = wr;
    addr      = a;
    byteEn    = be;
    writeData = wd;
    if (rd && push) sb.push_back('{exp, cyc + LAT});
  endtask

  task automatic settle();
    @(posedge clk); #1;
    memRead  = 1'b0;
    memWrite = 1'b0;
    byteEn   = 2'b00;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
`ifdef DATA_RAM_INIT_CLEAR_EN
    chk("ready_rise_edges", 32'(n), 32'(DEP));
`else
    chk("ready_rise_edges", 32'(n), 32'd0);
`endif
  endtask

  localparam logic RDY_RST =
`ifdef DATA_RAM_INIT_CLEAR_EN
    1'b0;
`else
    1'b1;
`endif

  initial begin
    rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    addr = '0; byteEn = '0; writeData = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readValid", 32'(readValid), 32'd0);
    chk("rst_readData", 32'(readData), 32'd0);
    chk("rst_addrErr", 32'(addrErr), 32'd0);
    chk("rst_ready", 32'(ready), 32'(RDY_RST));
    rst_n = 1'b1;
    wait_ready();

`ifdef DATA_RAM_INIT_CLEAR_EN
    op(1, 0, 8'h7F, 2'b00, 16'h0, 16'h0000, 1);
`endif
    // Byte-lane merge.
    op(0, 1, 8'h10, 2'b01, 16'hBEEF, 16'h0, 0);
    op(0, 1, 8'h10, 2'b10, 16'h1200, 16'h0, 0);
    op(1, 0, 8'h10, 2'b00, 16'h0,    16'h12EF, 1);
    settle();
    // Back-to-back reads.
    op(0, 1, 8'h01, 2'b11, 16'h00A1, 16'h0, 0);
    op(0, 1, 8'h02, 2'b11, 16'h00A2, 16'h0, 0);
    op(0, 1, 8'h03, 2'b11, 16'h00A3, 16'h0, 0);
    op(1, 0, 8'h01, 2'b00, 16'h0, 16'h00A1, 1);
    op(1, 0, 8'h02, 2'b00, 16'h0, 16'h00A2, 1);
    op(1, 0, 8'h03, 2'b00, 16'h0, 16'h00A3, 1);
    settle();
    // Read-first on collision, then new data.
    op(0, 1, 8'h20, 2'b11, 16'h1111, 16'h0, 0);
    op(1, 1, 8'h20, 2'b11, 16'h2222, 16'h1111, 1);
    op(1, 0, 8'h20, 2'b00, 16'h0,    16'h2222, 1);
    settle();
    // Write then immediate read of the same address.
    op(0, 1, 8'h30, 2'b11, 16'h3333, 16'h0, 0);
    op(1, 0, 8'h30, 2'b00, 16'h0, 16'h3333, 1);
    // byteEn=0 write is a no-op.
    op(0, 1, 8'h10, 2'b00, 16'hFFFF, 16'h0, 0);
    op(1, 0, 8'h10, 2'b00, 16'h0, 16'h12EF, 1);
    settle();
    chk("addrErr_clear_inrange", 32'(addrErr), 32'd0);
    // Out-of-range accesses.
    op(0, 1, 8'hC8, 2'b11, 16'h5555, 16'h0, 0);
    settle();
    chk("addrErr_set_write", 32'(addrErr), 32'd1);
    op(1, 0, 8'hC8, 2'b00, 16'h0, 16'h0000, 1);
    op(1, 0, 8'h10, 2'b00, 16'h0, 16'h12EF, 1);
    settle();
    repeat (6) @(posedge clk);
    #1;
    chk("addrErr_sticky", 32'(addrErr), 32'd1);

    // Reset one cycle after accepting a read: that read must never appear.
    op(1, 0, 8'h30, 2'b00, 16'h0, 16'h0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    #3;
    chk("midrst_readValid", 32'(readValid), 32'd0);
    chk("midrst_readData", 32'(readData), 32'd0);
    chk("midrst_addrErr", 32'(addrErr), 32'd0);
    chk("midrst_ready", 32'(ready), 32'(RDY_RST));
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_hold_valid", 32'(readValid), 32'd0);
    rst_n = 1'b1;
    wait_ready();
`ifdef DATA_RAM_INIT_CLEAR_EN
    op(1, 0, 8'h10, 2'b00, 16'h0, 16'h0000, 1);
`else
    op(1, 0, 8'h10, 2'b00, 16'h0, 16'h12EF, 1);
`endif
    settle();
    repeat (LAT + 6) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("addrErr_after_reset", 32'(addrErr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
